pwm_capture: RTL



---
 rtl/pwm_capture_pkg.sv | 15 +
 rtl/pwm_duty_div.sv | 91 +++++++++
 rtl/pwm_capture.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM period / high-time capture block and its duty divider.
package pwm_capture_pkg;

   localparam int unsigned DEF_CNT_W       = 16;
   localparam int unsigned DEF_DUTY_W      = 8;
   localparam int unsigned DEF_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } cap_state_e;

endpackage

// File: rtl/pwm_duty_div.sv
// Sequential restoring divider: quotient = floor(dividend * 2^DUTY_W / divisor), one bit per cycle.
// Assumes dividend < divisor; a start while busy aborts and restarts with the new operands.
module pwm_duty_div
   import pwm_capture_pkg::*;
#(
   parameter int unsigned DUTY_W = DEF_DUTY_W,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  dividend,
   input  logic [CNT_W-1:0]  divisor,
   output logic              busy,
   output logic              done,
   output logic [DUTY_W-1:0] quotient
);

   localparam int unsigned BIT_W = $clog2(DUTY_W + 1);

   logic [CNT_W-1:0]  rem_q,    rem_d;
   logic [CNT_W-1:0]  dvs_q,    dvs_d;
   logic [DUTY_W-2:0] quo_q,    quo_d;
   logic [DUTY_W-1:0] res_q,    res_d;
   logic [BIT_W-1:0]  bits_q,   bits_d;
   logic              busy_q,   busy_d;
   logic              done_q,   done_d;

   logic [CNT_W:0]    rem_sh;
   logic [CNT_W-1:0]  rem_sub;
   logic              take;
   logic [DUTY_W-1:0] quo_next;

   // One restoring step; the remainder always stays below the divisor so CNT_W bits suffice.
   always_comb begin
      rem_sh   = {rem_q, 1'b0};
      take     = (rem_sh >= {1'b0, dvs_q});
      rem_sub  = rem_sh[CNT_W-1:0] - dvs_q;
      quo_next = {quo_q, take};

      rem_d  = rem_q;
      dvs_d  = dvs_q;
      quo_d  = quo_q;
      res_d  = res_q;
      bits_d = bits_q;
      busy_d = busy_q;
      done_d = 1'b0;

      if (start) begin
         rem_d  = dividend;
         dvs_d  = divisor;
         quo_d  = '0;
         bits_d = BIT_W'(DUTY_W);
         busy_d = 1'b1;
      end else if (busy_q) begin
         rem_d  = take ? rem_sub : rem_sh[CNT_W-1:0];
         quo_d  = quo_next[DUTY_W-2:0];
         bits_d = bits_q - BIT_W'(1);
         if (bits_q == BIT_W'(1)) begin
            res_d  = quo_next;
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q  <= '0;
         dvs_q  <= '0;
         quo_q  <= '0;
         res_q  <= '0;
         bits_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         quo_q  <= quo_d;
         res_q  <= res_d;
         bits_q <= bits_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign quotient = res_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input, one result per complete period.
// Optional duty-cycle divider is built only when PWM_CAPTURE_DUTY_EN is defined.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned DUTY_W      = DEF_DUTY_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pwm_in,
   output logic [CNT_W-1:0]  period,
   output logic [CNT_W-1:0]  high_time,
   output logic              valid,
   output logic              timeout,
   output logic [DUTY_W-1:0] duty,
   output logic              duty_valid
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("pwm_capture: SYNC_STAGES must be at least 2");
   end

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] WARM_CNT = CNT_W'(SYNC_STAGES);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   cap_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       hi_lat_q, hi_lat_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic [CNT_W-1:0]       high_time_q, high_time_d;
   logic                   valid_q, valid_d;
   logic                   timeout_q, timeout_d;

   logic             s, rise, fall;
   logic [CNT_W-1:0] cnt_inc;

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~prev_q;
   assign fall = ~s & prev_q;

   // Next-state and measurement update.
   always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_d      = s;
      state_d     = state_q;
      cnt_d       = cnt_q;
      hi_lat_d    = hi_lat_q;
      period_d    = period_q;
      high_time_d = high_time_q;
      valid_d     = 1'b0;
      timeout_d   = timeout_q;
      cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

      unique case (state_q)
         // The sync chain resets to 0 regardless of the pin, so trust s only once it has filled.
         ST_IDLE: begin
            if (cnt_q < WARM_CNT) begin
               cnt_d = cnt_q + CNT_ONE;
            end else if (!s) begin
               state_d = ST_ARMED;
               cnt_d   = '0;
            end
         end
         ST_ARMED: begin
            if (rise) begin
               state_d = ST_HIGH;
               cnt_d   = CNT_ONE;
            end
         end
         ST_HIGH: begin
            cnt_d = cnt_inc;
            if (fall) begin
               hi_lat_d = cnt_q;
               state_d  = ST_LOW;
            end else if (cnt_q == CNT_MAX) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
               cnt_d     = '0;
            end
         end
         ST_LOW: begin
            cnt_d = cnt_inc;
            if (rise) begin
               period_d    = cnt_q;
               high_time_d = hi_lat_q;
               valid_d     = 1'b1;
               timeout_d   = 1'b0;
               cnt_d       = CNT_ONE;
               state_d     = ST_HIGH;
            end else if (cnt_q == CNT_MAX) begin
               timeout_d = 1'b1;
               state_d   = ST_IDLE;
               cnt_d     = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q      <= '0;
         prev_q      <= 1'b0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         hi_lat_q    <= '0;
         period_q    <= '0;
         high_time_q <= '0;
         valid_q     <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         prev_q      <= prev_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hi_lat_q    <= hi_lat_d;
         period_q    <= period_d;
         high_time_q <= high_time_d;
         valid_q     <= valid_d;
         timeout_q   <= timeout_d;
      end
   end

   assign period    = period_q;
   assign high_time = high_time_q;
   assign valid     = valid_q;
   assign timeout   = timeout_q;

`ifdef PWM_CAPTURE_DUTY_EN
   logic              div_busy, div_done;
   logic [DUTY_W-1:0] div_quo;

   pwm_duty_div #(
      .DUTY_W (DUTY_W),
      .CNT_W  (CNT_W)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (valid_q),
      .dividend (high_time_q),
      .divisor  (period_q),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quo)
   );

   // Result register inside the divider holds the last duty across restarts.
   assign duty       = div_quo;
   assign duty_valid = div_done & ~div_busy;
`else
   assign duty       = '0;
   assign duty_valid = 1'b0;
`endif

endmodule
